ctrl_pipe_unit: RTL
===================

Name: ctrl_pipe_unit

Overview:
- Parametrised successor to the single-cycle decode/control interface.
- Decodes a MIPS instruction word into the full control bundle and carries that bundle through PIPE_DEPTH registered stages.
- Uses valid/ready handshakes, stall and flush, and a sequencer that holds memory ops until dhit.
- Sits between fetch (upstream) and the execute/memory datapath (downstream).

Parameters:
WORD_W, 32, instruction word width
REG_W, 5, register specifier width (rs/rt/rd/shamt)
IMM_W, 16, immediate field width
PIPE_DEPTH, 2, number of registered control stages (1..4); sets decode-to-output latency

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, asynchronous, active-high
instr_valid  in  1  fetch presents an instruction
instr_ready  out  1  unit accepts an instruction this cycle
instruction  in  WORD_W  instruction word
stall  in  1  freeze all stages
flush  in  1  squash all in-flight entries
dhit  in  1  data memory op complete
out_valid  out  1  output bundle valid
ALUop  out  4  aluop_t from cpu_types_pkg
ALUsrc, pcsrc, RegDest  out  2 each  datapath selects
MemtoReg, WEN, dREN, dWEN, jal, extop, LUI, BEQ, branch, itype  out  1 each  control flags
rs, rt, rd, shamt  out  REG_W each  register fields
immed  out  IMM_W  immediate field
halt  out  1  sticky halt
busy  out  1  any stage valid or state != RUN

Behaviour:
- Reset (async, RST=1): all stage valid bits = 0, every output = 0, halt = 0, state = RUN. Reset mid-MEMWAIT abandons the op; dREN and dWEN drop immediately.
- Decode is combinational from instruction. Opcode map:
  - R-type 0x00 (JR funct 0x08 -> pcsrc=2).
  - J 0x02, JAL 0x03 (jal=1, RegDest=2, WEN=1).
  - BEQ 0x04, BNE 0x05.
  - ADDIU/ANDI/ORI/XORI/SLTI/SLTIU (itype=1).
  - LUI 0x0F.
  - LW 0x23 (dREN=1, MemtoReg=1).
  - SW 0x2B (dWEN=1).
  - HALT 0x3F.
  - Unknown opcode decodes to a bubble: WEN=dREN=dWEN=0, out_valid still 1.
- Accept: an instruction is accepted when instr_valid && instr_ready. instr_ready = (state==RUN) && !stall && !flush && !halt.
- Advance: stages shift when !stall && state==RUN. Stage 0 loads the decoded bundle with valid = accept. The output is the last stage. Latency from accept to out_valid = PIPE_DEPTH cycles.
- stall=1 holds every stage and all outputs exactly.
- flush=1: all valid bits clear next edge and out_valid=0. flush overrides stall and accept in the same cycle. flush in MEMWAIT returns to RUN and drops dREN/dWEN. halt is not cleared by flush.
- State machine (RUN, MEMWAIT, HALTED):
  - RUN -> MEMWAIT when the last stage becomes valid with dREN|dWEN. In MEMWAIT the output is held, the pipe is frozen and instr_ready=0.
  - MEMWAIT -> RUN on the cycle dhit=1. The pipe advances on that same edge.
  - RUN -> HALTED when a valid HALT reaches the last stage. halt=1 from that edge until RST. Younger stages are cleared, out_valid=0 after one cycle of valid HALT output, and instr_ready=0 permanently.
- Simultaneous dhit and flush: flush wins; no re-issue.
- Field extraction: rs=[25:21], rt=[20:16], rd=[15:11], shamt=[10:6], immed=[15:0], zero-extended to IMM_W.

Optional Feature:
- Macro: CTRL_PIPE_LLSC_EN.
- Defined:
  - LL 0x30 decodes as LW plus a link flag.
  - SC 0x38 decodes as SW, with WEN=1 and RegDest=rt for writing the success value.
  - Both use MEMWAIT.
  - An extra output port `llsc` (1 bit) is asserted with the bundle.
- Undefined: 0x30/0x38 decode as unknown (bubble), and the `llsc` port is absent.

Test Plan:
- RST pulse mid-stream, then ADDU 0x00221821 accepted at cycle 0 -> out_valid=1 at cycle PIPE_DEPTH with WEN=1, RegDest=1, rs=1, rt=2, rd=3; other controls 0.
- LW 0x8C220004 with dhit low for 3 cycles -> dREN=1, MemtoReg=1 held 3 cycles, instr_ready=0, busy=1; on the dhit cycle the pipe advances and the state returns to RUN.
- stall=1 for 2 cycles with a full pipe -> outputs unchanged. Then assert flush together with instr_valid -> out_valid=0 next cycle and the instruction is not accepted.
- HALT 0xFFFFFFFF followed by ORI -> halt=1 after PIPE_DEPTH cycles, the ORI never appears, instr_ready stays 0, and halt survives flush; only RST clears it.
- JAL 0x0C000010 -> jal=1, RegDest=2, WEN=1, pcsrc nonzero. Opcode 0x3E -> out_valid=1 with WEN=dREN=dWEN=0.
- With CTRL_PIPE_LLSC_EN defined: SC 0xE0410000 -> dWEN=1, WEN=1, llsc=1, enters MEMWAIT.

Source files
------------

// File: rtl/ctrl_pipe_unit_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ctrl_pipe_unit_if : fetch handshake + decoded control bundle (llsc only   |
// | with CTRL_PIPE_LLSC_EN)                                   Rev 1.0         |
// +--------------------------------------------------------------------------+
interface ctrl_pipe_unit_if #(
   parameter int WORD_W = 32,
   parameter int REG_W  = 5,
   parameter int IMM_W  = 16
);
   logic              instr_valid;
   logic              instr_ready;
   logic [WORD_W-1:0] instruction;
   logic              stall;
   logic              flush;
   logic              dhit;
   logic              out_valid;
   logic [3:0]        ALUop;
   logic [1:0]        ALUsrc;
   logic [1:0]        pcsrc;
   logic [1:0]        RegDest;
   logic              MemtoReg, WEN, dREN, dWEN, jal, extop, LUI, BEQ, branch, itype;
   logic [REG_W-1:0]  rs, rt, rd, shamt;
   logic [IMM_W-1:0]  immed;
   logic              halt;
   logic              busy;
`ifdef CTRL_PIPE_LLSC_EN
   logic              llsc;
`endif

   modport master (
      output instr_valid, instruction, stall, flush, dhit,
      input  instr_ready, out_valid, ALUop, ALUsrc, pcsrc, RegDest, MemtoReg, WEN,
             dREN, dWEN, jal, extop, LUI, BEQ, branch, itype, rs, rt, rd, shamt,
             immed, halt, busy
`ifdef CTRL_PIPE_LLSC_EN
      , input llsc
`endif
   );

   modport slave (
      input  instr_valid, instruction, stall, flush, dhit,
      output instr_ready, out_valid, ALUop, ALUsrc, pcsrc, RegDest, MemtoReg, WEN,
             dREN, dWEN, jal, extop, LUI, BEQ, branch, itype, rs, rt, rd, shamt,
             immed, halt, busy
`ifdef CTRL_PIPE_LLSC_EN
      , output llsc
`endif
   );
endinterface
`default_nettype wire

// File: rtl/ctrl_pipe_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ctrl_pipe_unit : MIPS decode + PIPE_DEPTH control stages with mem-op      |
// | sequencer. Optional LL/SC via CTRL_PIPE_LLSC_EN.          Rev 1.0         |
// +--------------------------------------------------------------------------+
module ctrl_pipe_unit #(
   parameter int WORD_W     = 32,
   parameter int REG_W      = 5,
   parameter int IMM_W      = 16,
   parameter int PIPE_DEPTH = 2
) (
   input  logic            CLK,
   input  logic            RST,
   ctrl_pipe_unit_if.slave bus
);
   typedef enum logic [1:0] {RUN = 2'd0, MEMWAIT = 2'd1, HALTED = 2'd2} state_t;

   localparam logic [3:0] ALU_SLL = 4'd0, ALU_SRL = 4'd1, ALU_ADD = 4'd2, ALU_SUB = 4'd3,
                          ALU_AND = 4'd4, ALU_OR  = 4'd5, ALU_XOR = 4'd6, ALU_NOR = 4'd7,
                          ALU_SLT = 4'd8, ALU_SLTU = 4'd9;

   typedef struct packed {
      logic [3:0]       ALUop;
      logic [1:0]       ALUsrc;
      logic [1:0]       pcsrc;
      logic [1:0]       RegDest;
      logic             MemtoReg, WEN, dREN, dWEN, jal, extop, LUI, BEQ, branch, itype;
      logic             is_halt;
`ifdef CTRL_PIPE_LLSC_EN
      logic             llsc;
`endif
      logic [REG_W-1:0] rs, rt, rd, shamt;
      logic [IMM_W-1:0] immed;
   } ctrl_t;

   ctrl_t                 dec, in_d, last_d, tail;
   ctrl_t                 stage_q [PIPE_DEPTH];
   logic [PIPE_DEPTH-1:0] valid_q;
   state_t                state_q;
   logic                  halt_q;
   logic                  last_v_d, ready, accept, advance, r_ok;
   logic [5:0]            op, funct;
   logic [3:0]            alu;
   logic                  unused_tail_halt;

   assign op    = bus.instruction[31:26];
   assign funct = bus.instruction[5:0];

   always_comb begin
      dec       = '0;
      alu       = ALU_ADD;
      r_ok      = 1'b1;
      dec.rs    = REG_W'(bus.instruction[25:21]);
      dec.rt    = REG_W'(bus.instruction[20:16]);
      dec.rd    = REG_W'(bus.instruction[15:11]);
      dec.shamt = REG_W'(bus.instruction[10:6]);
      dec.immed = IMM_W'(bus.instruction[15:0]);
      case (op)
         6'h00: begin
            case (funct)
               6'h00:        alu = ALU_SLL;
               6'h02:        alu = ALU_SRL;
               6'h20, 6'h21: alu = ALU_ADD;
               6'h22, 6'h23: alu = ALU_SUB;
               6'h24:        alu = ALU_AND;
               6'h25:        alu = ALU_OR;
               6'h26:        alu = ALU_XOR;
               6'h27:        alu = ALU_NOR;
               6'h2A:        alu = ALU_SLT;
               6'h2B:        alu = ALU_SLTU;
               6'h08: begin  r_ok = 1'b0; dec.pcsrc = 2'd2; end
               default:      r_ok = 1'b0;
            endcase
            if (r_ok) begin
               dec.ALUop   = alu;
               dec.RegDest = 2'd1;
               dec.WEN     = 1'b1;
               dec.ALUsrc  = (funct == 6'h00 || funct == 6'h02) ? 2'd2 : 2'd0;
            end
         end
         6'h02: dec.pcsrc = 2'd3;
         6'h03: begin dec.pcsrc = 2'd3; dec.jal = 1'b1; dec.RegDest = 2'd2; dec.WEN = 1'b1; end
         6'h04: begin dec.BEQ = 1'b1; dec.branch = 1'b1; dec.pcsrc = 2'd1; dec.ALUop = ALU_SUB; end
         6'h05: begin dec.branch = 1'b1; dec.pcsrc = 2'd1; dec.ALUop = ALU_SUB; end
         6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E: begin
            dec.itype  = 1'b1;
            dec.WEN    = 1'b1;
            dec.ALUsrc = 2'd1;
            dec.extop  = (op <= 6'h0B);  // arithmetic/compare sign-extend, logicals zero-extend
            case (op)
               6'h09:   dec.ALUop = ALU_ADD;
               6'h0A:   dec.ALUop = ALU_SLT;
               6'h0B:   dec.ALUop = ALU_SLTU;
               6'h0C:   dec.ALUop = ALU_AND;
               6'h0D:   dec.ALUop = ALU_OR;
               default: dec.ALUop = ALU_XOR;
            endcase
         end
         6'h0F: begin dec.LUI = 1'b1; dec.WEN = 1'b1; dec.ALUsrc = 2'd1; end
         6'h23: begin
            dec.dREN = 1'b1; dec.MemtoReg = 1'b1; dec.WEN = 1'b1;
            dec.ALUsrc = 2'd1; dec.extop = 1'b1; dec.ALUop = ALU_ADD;
         end
         6'h2B: begin dec.dWEN = 1'b1; dec.ALUsrc = 2'd1; dec.extop = 1'b1; dec.ALUop = ALU_ADD; end
`ifdef CTRL_PIPE_LLSC_EN
         6'h30: begin
            dec.dREN = 1'b1; dec.MemtoReg = 1'b1; dec.WEN = 1'b1; dec.llsc = 1'b1;
            dec.ALUsrc = 2'd1; dec.extop = 1'b1; dec.ALUop = ALU_ADD;
         end
         6'h38: begin
            dec.dWEN = 1'b1; dec.WEN = 1'b1; dec.llsc = 1'b1;
            dec.ALUsrc = 2'd1; dec.extop = 1'b1; dec.ALUop = ALU_ADD;
         end
`endif
         6'h3F:   dec.is_halt = 1'b1;
         default: ;
      endcase
   end

   assign ready   = (state_q == RUN) && !bus.stall && !bus.flush && !halt_q;
   assign accept  = bus.instr_valid && ready;
   assign advance = !bus.flush && !bus.stall &&
                    ((state_q == RUN) || (state_q == MEMWAIT && bus.dhit));
   // Bubbles carry an all-zero bundle so side-effect controls never leak out.
   assign in_d    = accept ? dec : '0;

   if (PIPE_DEPTH == 1) begin : g_tail_direct
      assign last_d   = in_d;
      assign last_v_d = accept;
   end else begin : g_tail_shift
      assign last_d   = stage_q[PIPE_DEPTH-2];
      assign last_v_d = valid_q[PIPE_DEPTH-2];
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < PIPE_DEPTH; i++) stage_q[i] <= '0;
         valid_q <= '0;
         state_q <= RUN;
         halt_q  <= 1'b0;
      end else if (bus.flush || state_q == HALTED) begin
         for (int i = 0; i < PIPE_DEPTH; i++) stage_q[i] <= '0;
         valid_q <= '0;
         if (state_q == MEMWAIT) state_q <= RUN;
      end else if (advance) begin
         stage_q[0] <= in_d;
         valid_q[0] <= accept;
         for (int i = 1; i < PIPE_DEPTH; i++) begin
            stage_q[i] <= stage_q[i-1];
            valid_q[i] <= valid_q[i-1];
         end
         if (last_v_d && last_d.is_halt) begin
            state_q <= HALTED;
            halt_q  <= 1'b1;
            for (int i = 0; i < PIPE_DEPTH - 1; i++) begin
               stage_q[i] <= '0;
               valid_q[i] <= 1'b0;
            end
         end else if (last_v_d && (last_d.dREN || last_d.dWEN)) begin
            state_q <= MEMWAIT;
         end else begin
            state_q <= RUN;
         end
      end
   end

   assign tail             = stage_q[PIPE_DEPTH-1];
   assign unused_tail_halt = tail.is_halt;

   assign bus.instr_ready = ready;
   assign bus.out_valid   = valid_q[PIPE_DEPTH-1];
   assign bus.ALUop       = tail.ALUop;
   assign bus.ALUsrc      = tail.ALUsrc;
   assign bus.pcsrc       = tail.pcsrc;
   assign bus.RegDest     = tail.RegDest;
   assign bus.MemtoReg    = tail.MemtoReg;
   assign bus.WEN         = tail.WEN;
   assign bus.dREN        = tail.dREN;
   assign bus.dWEN        = tail.dWEN;
   assign bus.jal         = tail.jal;
   assign bus.extop       = tail.extop;
   assign bus.LUI         = tail.LUI;
   assign bus.BEQ         = tail.BEQ;
   assign bus.branch      = tail.branch;
   assign bus.itype       = tail.itype;
   assign bus.rs          = tail.rs;
   assign bus.rt          = tail.rt;
   assign bus.rd          = tail.rd;
   assign bus.shamt       = tail.shamt;
   assign bus.immed       = tail.immed;
   assign bus.halt        = halt_q;
   assign bus.busy        = (|valid_q) || (state_q != RUN);
`ifdef CTRL_PIPE_LLSC_EN
   assign bus.llsc        = tail.llsc;
`endif
endmodule
`default_nettype wire
